// File: rtl/prog_loader.sv
// Serial program loader: receives a LEN/data/SUM frame and writes the data bytes into
// CPU RAM through the MAR/RAM bus while holding the CPU off the bus.
module prog_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [15:0] bus_out,
  output logic        bus_en,
  output logic        mar_we,
  output logic        ram_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGetLen,
    StGetData,
    StSetAddr,
    StWrite,
    StGetSum,
    StDone,
    StErr
  } state_e;

  state_e            state_q;
  logic [8:0]        len_q;
  // Bytes written so far; its low byte is the current RAM address.
  logic [8:0]        wr_cnt_q;
  logic [7:0]        sum_q;
  logic [7:0]        data_q;
  logic [TimerW-1:0] timer_q;

  logic waiting;
  logic timed_out;
  logic overrun;
  logic bad_sum;
  logic go_err;

  always_comb begin
    waiting   = (state_q == StGetLen) || (state_q == StGetData) || (state_q == StGetSum);
    timed_out = waiting && !rx_valid && (timer_q == TimerLast);
    overrun   = rx_valid && ((state_q == StSetAddr) || (state_q == StWrite));
    bad_sum   = rx_valid && (state_q == StGetSum) && (rx_data != sum_q);
    go_err    = timed_out || overrun || bad_sum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      wr_cnt_q <= '0;
      sum_q    <= '0;
      data_q   <= '0;
      timer_q  <= '0;
      bus_out  <= '0;
      bus_en   <= 1'b0;
      mar_we   <= 1'b0;
      ram_we   <= 1'b0;
      cpu_hold <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      // Bus strobes are single-cycle; only the SET_ADDR/WRITE entries raise them.
      bus_out <= '0;
      bus_en  <= 1'b0;
      mar_we  <= 1'b0;
      ram_we  <= 1'b0;
      if (go_err) begin
        state_q  <= StErr;
        error    <= 1'b1;
        busy     <= 1'b0;
        cpu_hold <= 1'b0;
        timer_q  <= '0;
      end else begin
        case (state_q)
          StIdle, StDone, StErr: begin
            if (start) begin
              state_q  <= StGetLen;
              done     <= 1'b0;
              error    <= 1'b0;
              wr_cnt_q <= '0;
              sum_q    <= '0;
              timer_q  <= '0;
              busy     <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
          StGetLen: begin
            if (rx_valid) begin
              len_q   <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
              timer_q <= '0;
              state_q <= StGetData;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          StGetData: begin
            if (rx_valid) begin
              data_q  <= rx_data;
              sum_q   <= sum_q + rx_data;
              timer_q <= '0;
              bus_en  <= 1'b1;
              mar_we  <= 1'b1;
              bus_out <= {8'h00, wr_cnt_q[7:0]};
              state_q <= StSetAddr;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          StSetAddr: begin
            bus_en  <= 1'b1;
            ram_we  <= 1'b1;
            bus_out <= {8'h00, data_q};
            state_q <= StWrite;
          end
          StWrite: begin
            wr_cnt_q <= wr_cnt_q + 9'd1;
            state_q  <= (wr_cnt_q + 9'd1 == len_q) ? StGetSum : StGetData;
          end
          StGetSum: begin
            if (rx_valid) begin
              state_q  <= StDone;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
              timer_q  <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a cycle-indexed schedule of expected bus strobes and status flags,
// built from frame-level rules, is checked every cycle; captured RAM writes pin the results.
module tb_prog_loader;

  localparam int unsigned TO = 10;
  localparam int NC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] bus_out;
  logic        bus_en, mar_we, ram_we, cpu_hold, busy, done, error;

  prog_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .bus_out  (bus_out),
    .bus_en   (bus_en),
    .mar_we   (mar_we),
    .ram_we   (ram_we),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected schedule: strobes {mar,ram} with bus byte, and flag updates {busy,hold,done,err}.
  logic [1:0] e_stb [NC];
  logic [7:0] e_bus [NC];
  logic       e_set [NC];
  logic [3:0] e_flg [NC];
  logic [3:0] cur_flg = 4'b0000;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_sum;
  logic [7:0] m_addr;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < NC) begin
      if (e_set[cyc]) cur_flg = e_flg[cyc];
      chk("busy", 16'(busy), 16'(cur_flg[3]));
      chk("cpu_hold", 16'(cpu_hold), 16'(cur_flg[2]));
      chk("done", 16'(done), 16'(cur_flg[1]));
      chk("error", 16'(error), 16'(cur_flg[0]));
      chk("bus_en", 16'(bus_en), 16'(|e_stb[cyc]));
      chk("mar_we", 16'(mar_we), 16'(e_stb[cyc][1]));
      chk("ram_we", 16'(ram_we), 16'(e_stb[cyc][0]));
      if (|e_stb[cyc]) chk("bus_out", bus_out, {8'h00, e_bus[cyc]});
    end
  end

  // Bus-side view of the CPU memory: MAR latch plus a log of RAM writes.
  logic [7:0] mar_m = 8'h00;
  logic [7:0] log_a [1024];
  logic [7:0] log_d [1024];
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (mar_we) mar_m <= bus_out[7:0];
    if (ram_we && wr_cnt < 1024) begin
      log_a[wr_cnt] <= mar_m;
      log_d[wr_cnt] <= bus_out[7:0];
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sched_flags(input int c, input logic [3:0] f);
    if (c < NC) begin
      e_set[c] = 1'b1;
      e_flg[c] = f;
    end
  endtask

  task automatic sched_stb(input int c, input logic [1:0] s, input logic [7:0] v);
    if (c < NC) begin
      e_stb[c] = s;
      e_bus[c] = v;
    end
  endtask

  task automatic do_start(input logic with_rx);
    start    = 1'b1;
    rx_valid = with_rx;
    rx_data  = 8'h03;
    sched_flags(cyc + 1, 4'b1100);
    m_sum  = 8'h00;
    m_addr = 8'h00;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic send_len(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // MAR write one cycle after acceptance, RAM write the cycle after that.
  task automatic send_data(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    sched_stb(cyc + 1, 2'b10, m_addr);
    sched_stb(cyc + 2, 2'b01, b);
    m_addr = m_addr + 8'd1;
    m_sum  = m_sum + b;
    tick();
    rx_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_sum(input logic [7:0] b);
    logic ok;
    ok = (b == m_sum);
    rx_valid = 1'b1;
    rx_data  = b;
    sched_flags(cyc + 1, {2'b00, ok, !ok});
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  int base;

  initial begin
    for (int i = 0; i < NC; i++) begin
      e_stb[i] = 2'b00;
      e_bus[i] = 8'h00;
      e_set[i] = 1'b0;
      e_flg[i] = 4'b0000;
    end
    repeat (3) tick();
    chk("rst_bus_out", bus_out, 16'h0000);
    rst = 1'b1;
    tick();

    // Nominal load; start+rx in IDLE must not consume the byte, start while busy ignored.
    base = wr_cnt;
    do_start(1'b1);
    send_len(8'h03);
    send_data(8'hA1);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_data(8'hB2);
    send_data(8'hC3);
    send_sum(8'h16);
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    tick();
    rx_valid = 1'b0;
    tick();
    chk("nom_done", 16'(done), 16'h1);
    chk("nom_error", 16'(error), 16'h0);
    chk("nom_hold", 16'(cpu_hold), 16'h0);
    chk("nom_wr_count", 16'(wr_cnt - base), 16'd3);
    chk("nom_w0", {log_a[base], log_d[base]}, 16'h00A1);
    chk("nom_w1", {log_a[base+1], log_d[base+1]}, 16'h01B2);
    chk("nom_w2", {log_a[base+2], log_d[base+2]}, 16'h02C3);

    // Bad checksum.
    base = wr_cnt;
    do_start(1'b0);
    send_len(8'h01);
    send_data(8'h55);
    send_sum(8'h54);
    chk("bad_error", 16'(error), 16'h1);
    chk("bad_done", 16'(done), 16'h0);
    chk("bad_wr_count", 16'(wr_cnt - base), 16'd1);
    chk("bad_w0", {log_a[base], log_d[base]}, 16'h0055);

    // Full page: LEN 0 means 256 bytes.
    base = wr_cnt;
    do_start(1'b0);
    send_len(8'h00);
    for (int i = 0; i < 256; i++) send_data(8'(i));
    send_sum(8'h80);
    tick();
    chk("page_done", 16'(done), 16'h1);
    chk("page_wr_count", 16'(wr_cnt - base), 16'd256);
    for (int i = 0; i < 256; i++) chk("page_wr", {log_a[base+i], log_d[base+i]}, {8'(i), 8'(i)});

    // Timeout after one of two data bytes.
    base = wr_cnt;
    do_start(1'b0);
    send_len(8'h02);
    send_data(8'h11);
    sched_flags(cyc + int'(TO), 4'b0001);
    repeat (TO + 4) tick();
    chk("to_error", 16'(error), 16'h1);
    chk("to_wr_count", 16'(wr_cnt - base), 16'd1);

    // Overrun during SET_ADDR: MAR written, RAM write for that address suppressed.
    base = wr_cnt;
    do_start(1'b0);
    send_len(8'h02);
    send_data(8'h22);
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    sched_stb(cyc + 1, 2'b10, m_addr);
    tick();
    rx_data = 8'h44;
    sched_flags(cyc + 1, 4'b0001);
    tick();
    rx_valid = 1'b0;
    repeat (3) tick();
    chk("ovr_error", 16'(error), 16'h1);
    chk("ovr_wr_count", 16'(wr_cnt - base), 16'd1);
    chk("ovr_w0", {log_a[base], log_d[base]}, 16'h0022);

    // Reset asserted mid-WRITE, then a fresh load restarts at address 00.
    base = wr_cnt;
    do_start(1'b0);
    send_len(8'h03);
    send_data(8'h9C);
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    sched_stb(cyc + 1, 2'b10, m_addr);
    tick();
    rx_valid = 1'b0;
    tick();
    sched_flags(cyc, 4'b0000);
    e_stb[cyc] = 2'b00;
    rst = 1'b0;
    #1;
    chk("rst_ram_we", 16'(ram_we), 16'h0);
    chk("rst_bus_en", 16'(bus_en), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_hold", 16'(cpu_hold), 16'h0);
    chk("rst_bus_out2", bus_out, 16'h0000);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_wr_count", 16'(wr_cnt - base), 16'd1);
    base = wr_cnt;
    do_start(1'b0);
    send_len(8'h01);
    send_data(8'h77);
    send_sum(8'h77);
    chk("rst2_done", 16'(done), 16'h1);
    chk("rst2_w0", {log_a[base], log_d[base]}, 16'h0077);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 50000, idle cycles allowed between accepted bytes before abort.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; asserting low forces reset state immediately, release synchronous to clk.
REQ-004 start  input  1  single-cycle request to begin a program load.
REQ-005 rx_valid  input  1  single-cycle strobe; rx_data holds a received byte.
REQ-006 rx_data  input  8  received byte, valid only while rx_valid=1.
REQ-007 bus_out  output  16  value driven onto the CPU bus while bus_en=1.
REQ-008 bus_en  output  1  loader owns the bus this cycle.
REQ-009 mar_we  output  1  memory address register write enable.
REQ-010 ram_we  output  1  RAM write enable, writes bus_out[7:0] at the current MAR.
REQ-011 cpu_hold  output  1  holds the CPU off the bus and halted while 1.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  sticky; last load completed with a matching checksum.
REQ-014 error  output  1  sticky; last load aborted (checksum, timeout, overrun).

Function
REQ-015 Load frame, in order: LEN byte (0 means 256, else 1..255), then N data bytes, then SUM byte.
REQ-016 States: IDLE, GET_LEN, GET_DATA, SET_ADDR, WRITE, GET_SUM, DONE, ERR.
REQ-017 IDLE/DONE/ERR + start=1 -> GET_LEN next cycle; clear done, error, addr, sum and timer; set busy=1 and cpu_hold=1.
REQ-018 start while busy=1 is ignored.
REQ-019 GET_LEN + rx_valid: latch N (LEN 0 -> 256, held in 9 bits) -> GET_DATA.
REQ-020 GET_DATA + rx_valid: latch byte, sum <= sum + byte mod 256 -> SET_ADDR.
REQ-021 SET_ADDR, exactly one cycle: bus_en=1, mar_we=1, bus_out={8'h00, addr} -> WRITE.
REQ-022 WRITE, exactly one cycle: bus_en=1, ram_we=1, bus_out={8'h00, byte}; addr increments, wrapping 8 bits.
REQ-023 WRITE exit: to GET_SUM if the count of bytes written equals N, else to GET_DATA.
REQ-024 Per-byte write latency: MAR written on the edge ending SET_ADDR; RAM written on the edge ending WRITE; 2 cycles after the accepting edge.
REQ-025 mar_we, ram_we and bus_en are never asserted in the same cycle as each other's phase: mar_we and ram_we are mutually exclusive.
REQ-026 All three (mar_we, ram_we, bus_en) are 0 outside SET_ADDR/WRITE.
REQ-027 GET_SUM + rx_valid: rx_data == sum -> DONE (done=1), else -> ERR (error=1).
REQ-028 DONE/ERR: busy=0, cpu_hold=0; done/error held until the next start or reset.
REQ-029 Overrun: rx_valid in SET_ADDR or WRITE -> ERR after completing the current cycle; the byte is discarded.
REQ-030 An aborted WRITE is not issued; any RAM bytes already written stay written.
REQ-031 rx_valid in IDLE/DONE/ERR is ignored with no flag change.
REQ-032 Timer: in GET_LEN/GET_DATA/GET_SUM counts cycles since entry/last accepted byte; reaching TIMEOUT_CYCLES -> ERR.
REQ-033 Timer: reset by every accepted byte; held at 0 in other states.
REQ-034 start and rx_valid in the same cycle in IDLE: start wins, rx_data ignored.

Reset
REQ-035 rst low at any time, including mid-load, forces IDLE.
REQ-036 Reset values: all outputs 0, bus_out=16'h0000; addr, sum, N and timer cleared.
REQ-037 No memory write enable may glitch high during or after reset.

Verification
REQ-038 Nominal load: start; bytes 03,A1,B2,C3,16 -> writes A1@00, B2@01, C3@02 (MAR then RAM on consecutive cycles), done=1, error=0, cpu_hold=0.
REQ-039 Bad checksum: start; bytes 01,55,54 -> one write 55@00, then error=1, done=0.
REQ-040 Full page: LEN 00, data bytes 00..FF, SUM 80 -> 256 writes at addr 00..FF, no 9-bit wrap to addr 00, done=1.
REQ-041 Timeout: TIMEOUT_CYCLES=10, start, LEN 02, one data byte, then silence -> error=1 exactly 10 cycles after the write sequence ends.
REQ-042 Overrun: rx_valid during SET_ADDR -> ERR, and no ram_we pulse for that address.
REQ-043 Reset mid-load: rst low during WRITE -> all outputs 0 immediately; a later start restarts at addr 00.
